// File: rtl/arf_rename_param_if.sv
// rtl/arf_rename_param_if.sv - dispatch/commit/read bus for the ARF rename table
interface arf_rename_param_if #(
    parameter int NUM_RD  = 4,
    parameter int NUM_DP  = 2,
    parameter int NUM_COM = 2,
    parameter int ARF_SEL = 5,
    parameter int RRF_SEL = 6,
    parameter int DATA_W  = 32
);
    logic [NUM_RD*ARF_SEL-1:0]  i_rd_addr;
    logic [NUM_RD-1:0]          o_rd_busy;
    logic [NUM_RD*RRF_SEL-1:0]  o_rd_rrftag;
    logic [NUM_RD*DATA_W-1:0]   o_rd_data;
    logic [NUM_DP-1:0]          i_dp_vld;
    logic [NUM_DP*RRF_SEL-1:0]  i_dp_ptr;
    logic [NUM_DP-1:0]          i_dp_wr_en;
    logic [NUM_DP*ARF_SEL-1:0]  i_dp_wr_addr;
    logic [NUM_COM-1:0]         i_com_vld;
    logic [NUM_COM-1:0]         i_com_wr_en;
    logic [NUM_COM*ARF_SEL-1:0] i_com_wr_addr;
    logic [NUM_COM*RRF_SEL-1:0] i_com_ptr;
    logic [NUM_COM*DATA_W-1:0]  i_com_wr_data;
    logic                       i_flush;
    logic [ARF_SEL:0]           o_busy_cnt;

    modport master (
        output i_rd_addr, i_dp_vld, i_dp_ptr, i_dp_wr_en, i_dp_wr_addr,
               i_com_vld, i_com_wr_en, i_com_wr_addr, i_com_ptr, i_com_wr_data, i_flush,
        input  o_rd_busy, o_rd_rrftag, o_rd_data, o_busy_cnt
    );

    modport slave (
        input  i_rd_addr, i_dp_vld, i_dp_ptr, i_dp_wr_en, i_dp_wr_addr,
               i_com_vld, i_com_wr_en, i_com_wr_addr, i_com_ptr, i_com_wr_data, i_flush,
        output o_rd_busy, o_rd_rrftag, o_rd_data, o_busy_cnt
    );
endinterface

// File: rtl/arf_rename_param.sv
// rtl/arf_rename_param.sv - architectural register file with rename busy/tag table
// Optional ARF_COM_BYPASS_EN: same-cycle commit data/busy-clear visible on the read ports.
module arf_rename_param #(
    parameter int NUM_RD  = 4,
    parameter int NUM_DP  = 2,
    parameter int NUM_COM = 2,
    parameter int ARF_SEL = 5,
    parameter int RRF_SEL = 6,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    arf_rename_param_if.slave  bus
);
    localparam int NREG  = 2**ARF_SEL;
    localparam int CNT_W = ARF_SEL + 1;

    logic [DATA_W-1:0]  data_q [NREG];
    logic [DATA_W-1:0]  data_d [NREG];
    logic [RRF_SEL-1:0] tag_q  [NREG];
    logic [RRF_SEL-1:0] tag_d  [NREG];
    logic [NREG-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ARF_SEL-1:0] rd_addr  [NUM_RD];
    logic [ARF_SEL-1:0] dp_addr  [NUM_DP];
    logic [RRF_SEL-1:0] dp_ptr   [NUM_DP];
    logic [NUM_DP-1:0]  dp_act;
    logic [ARF_SEL-1:0] com_addr [NUM_COM];
    logic [RRF_SEL-1:0] com_ptr  [NUM_COM];
    logic [DATA_W-1:0]  com_data [NUM_COM];
    logic [NUM_COM-1:0] com_act;

    logic [NUM_RD-1:0]          rd_busy;
    logic [NUM_RD*RRF_SEL-1:0]  rd_tag;
    logic [NUM_RD*DATA_W-1:0]   rd_data;

    // Register 0 is excluded here, so it can never be written or marked busy.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_addr[p] = bus.i_rd_addr[p*ARF_SEL +: ARF_SEL];
    end
    for (genvar k = 0; k < NUM_DP; k++) begin : g_dp
        assign dp_addr[k] = bus.i_dp_wr_addr[k*ARF_SEL +: ARF_SEL];
        assign dp_ptr[k]  = bus.i_dp_ptr[k*RRF_SEL +: RRF_SEL];
        assign dp_act[k]  = bus.i_dp_vld[k] & bus.i_dp_wr_en[k] & (dp_addr[k] != '0);
    end
    for (genvar j = 0; j < NUM_COM; j++) begin : g_com
        assign com_addr[j] = bus.i_com_wr_addr[j*ARF_SEL +: ARF_SEL];
        assign com_ptr[j]  = bus.i_com_ptr[j*RRF_SEL +: RRF_SEL];
        assign com_data[j] = bus.i_com_wr_data[j*DATA_W +: DATA_W];
        assign com_act[j]  = bus.i_com_vld[j] & bus.i_com_wr_en[j] & (com_addr[j] != '0);
    end

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        cnt_d  = '0;
        for (int j = 0; j < NUM_COM; j++) begin
            if (com_act[j]) data_d[com_addr[j]] = com_data[j];
        end
        if (bus.i_flush) begin
            busy_d = '0;
        end else begin
            // Clears go first so a same-cycle rename of the register overrides them.
            for (int j = 0; j < NUM_COM; j++) begin
                if (com_act[j] && (tag_q[com_addr[j]] == com_ptr[j])) busy_d[com_addr[j]] = 1'b0;
            end
            for (int k = 0; k < NUM_DP; k++) begin
                if (dp_act[k]) begin
                    busy_d[dp_addr[k]] = 1'b1;
                    tag_d[dp_addr[k]]  = dp_ptr[k];
                end
            end
        end
        for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_busy[p]                   = busy_q[rd_addr[p]];
            rd_tag[p*RRF_SEL +: RRF_SEL] = tag_q[rd_addr[p]];
            rd_data[p*DATA_W +: DATA_W]  = data_q[rd_addr[p]];
`ifdef ARF_COM_BYPASS_EN
            for (int j = 0; j < NUM_COM; j++) begin
                if (com_act[j] && (com_addr[j] == rd_addr[p])) begin
                    rd_data[p*DATA_W +: DATA_W] = com_data[j];
                    rd_busy[p] = busy_q[rd_addr[p]] && (com_ptr[j] != tag_q[rd_addr[p]]);
                end
            end
`endif
        end
    end

    assign bus.o_rd_busy   = rd_busy;
    assign bus.o_rd_rrftag = rd_tag;
    assign bus.o_rd_data   = rd_data;
    assign bus.o_busy_cnt  = cnt_q;
endmodule
